// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle over the 256x8 S memory (S assumed to hold the identity).
// One swap per 6-cycle iteration; all outputs are registered and decoded from the next state.
module ksa_shuffle_fsm #(
  parameter int KEY_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_LEN-1:0]   secret_key,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wren,
  output logic                   finish
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_I, CALC_J, RD_J, LAT_J, WR_I, WR_J, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           i_q, i_d, j_q, j_d;
  logic [KW-1:0]        kidx_q, kidx_d;
  logic [7:0]           si_q, si_d, sj_q, sj_d;
  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic [7:0]           mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                 mem_wren_q, mem_wren_d, finish_q, finish_d;

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [8*KEY_LEN-1:0] key,
                                          input logic [KW-1:0] idx);
    logic [8*KEY_LEN-1:0] sh;
    sh = key >> (8 * (KEY_LEN - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    kidx_d      = kidx_q;
    si_d        = si_q;
    sj_d        = sj_q;
    key_d       = key_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wren_d  = 1'b0;
    finish_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          key_d   = secret_key;
          state_d = RD_I;
        end
      end
      RD_I: state_d = CALC_J;
      CALC_J: begin
        si_d       = mem_rdata;
        j_d        = j_q + mem_rdata + key_byte(key_q, kidx_q);
        mem_addr_d = j_d;
        state_d    = RD_J;
      end
      RD_J: state_d = LAT_J;
      LAT_J: begin
        sj_d        = mem_rdata;
        mem_addr_d  = i_q;
        mem_wdata_d = mem_rdata;
        mem_wren_d  = 1'b1;
        state_d     = WR_I;
      end
      WR_I: begin
        mem_addr_d  = j_q;
        mem_wdata_d = si_q;
        mem_wren_d  = 1'b1;
        state_d     = WR_J;
      end
      WR_J: begin
        if (i_q == 8'd255) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end else begin
          i_d        = i_q + 8'd1;
          kidx_d     = (kidx_q == KW'(KEY_LEN - 1)) ? '0 : kidx_q + 1'b1;
          mem_addr_d = i_d;
          state_d    = RD_I;
        end
      end
      DONE: finish_d = 1'b1;
      default: state_d = IDLE;
    endcase
    // Dropping start anywhere outside IDLE aborts the run with outputs cleared.
    if (state_q != IDLE && !start) begin
      state_d     = IDLE;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_wren_d  = 1'b0;
      finish_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      kidx_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      kidx_q      <= kidx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      finish_q    <= finish_d;
    end
  end

  always_ff @(posedge clk) begin
    si_q  <= si_d;
    sj_q  <= sj_d;
    key_q <= key_d;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: behavioural S RAM, write log and a plain RC4 KSA reference.
module tb_ksa_shuffle_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_addr, mem_wdata;
  logic        mem_wren, finish;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [256];
  logic       mem_init = 1'b0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];

  logic [7:0] exp_s [256];
  logic [7:0] exp_a [512];
  logic [7:0] exp_d [512];

  ksa_shuffle_fsm #(.KEY_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .finish(finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'(k);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    mem_rdata <= ram[mem_addr];
  end

  // Textbook KSA from the identity, recording the swap writes in order.
  function automatic void ksa_model(input logic [23:0] key);
    int s[256];
    int j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + s[i] + int'((key >> (8 * (2 - (i % 3)))) & 24'hFF)) % 256;
      exp_a[2*i]   = 8'(i);
      exp_d[2*i]   = 8'(s[j]);
      exp_a[2*i+1] = 8'(j);
      exp_d[2*i+1] = 8'(s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(s[k]);
  endfunction

  task automatic init_ram();
    @(negedge clk) mem_init = 1'b1;
    @(negedge clk) mem_init = 1'b0;
  endtask

  // Full run; leaves start high with the DUT holding finish.
  task automatic run_full(input logic [23:0] key, input int chg_cycle, input logic [23:0] chg_key,
                          output int base);
    int cnt, bad, nw;
    ksa_model(key);
    init_ram();
    base = wa.size();
    secret_key = key;
    start = 1'b1;
    @(posedge clk);
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == chg_cycle) secret_key = chg_key;
      if (finish === 1'b1) break;
    end
    checks++;
    if (cnt !== 1536) begin
      errors++; $display("FAIL latency key=%h got %0d edges want 1536", key, cnt);
    end
    nw = wa.size() - base;
    checks++;
    if (nw !== 512) begin
      errors++; $display("FAIL wr_count key=%h got %0d want 512", key, nw);
    end
    bad = -1;
    for (int k = 0; k < 512; k++) begin
      if (base + k >= wa.size()) begin bad = k; break; end
      if (wa[base+k] !== exp_a[k] || wd[base+k] !== exp_d[k]) begin bad = k; break; end
    end
    checks++;
    if (bad != -1) begin
      errors++;
      if (base + bad < wa.size())
        $display("FAIL wr_seq key=%h idx %0d got (%0d,%0d) want (%0d,%0d)", key, bad,
                 wa[base+bad], wd[base+bad], exp_a[bad], exp_d[bad]);
      else
        $display("FAIL wr_seq key=%h idx %0d got none want (%0d,%0d)", key, bad,
                 exp_a[bad], exp_d[bad]);
    end
    bad = -1;
    for (int k = 0; k < 256; k++)
      if (ram[k] !== exp_s[k]) begin bad = k; break; end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL final_s key=%h S[%0d] got %0d want %0d", key, bad, ram[bad], exp_s[bad]);
    end
  endtask

  task automatic end_run();
    @(negedge clk) start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_wren, finish, mem_addr, mem_wdata} !== 18'd0) begin
      errors++; $display("FAIL reset_out got wren=%b fin=%b addr=%0d wd=%0d want all 0",
                         mem_wren, finish, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_keys();
    logic [7:0] ka [8];
    logic [7:0] kd [8];
    int base;
    ka = '{0, 0, 1, 1, 2, 3, 3, 5};
    kd = '{0, 0, 1, 1, 3, 2, 5, 2};
    run_full(24'h000000, -1, 24'h0, base);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wa[base+k] !== ka[k] || wd[base+k] !== kd[k]) begin
        errors++; $display("FAIL key0_wr%0d got (%0d,%0d) want (%0d,%0d)", k,
                           wa[base+k], wd[base+k], ka[k], kd[k]);
      end
    end
    end_run();
    run_full(24'h010203, -1, 24'h0, base);
    checks++;
    if (wa[base] !== 8'd0 || wd[base] !== 8'd1 || wa[base+1] !== 8'd1 || wd[base+1] !== 8'd0) begin
      errors++; $display("FAIL key010203_first got (%0d,%0d)(%0d,%0d) want (0,1)(1,0)",
                         wa[base], wd[base], wa[base+1], wd[base+1]);
    end
    end_run();
  endtask

  task automatic test_handshake();
    int base, n;
    run_full(24'($urandom), -1, 24'h0, base);
    n = wa.size();
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (finish !== 1'b1) begin
        errors++; $display("FAIL finish_hold got %b want 1", finish);
      end
    end
    checks++;
    if (wa.size() !== n) begin
      errors++; $display("FAIL done_writes got %0d want %0d", wa.size(), n);
    end
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (finish !== 1'b0) begin
      errors++; $display("FAIL finish_drop got %b want 0", finish);
    end
    run_full(24'($urandom), -1, 24'h0, base);
    end_run();
  endtask

  task automatic test_abort();
    int n;
    int base;
    init_ram();
    secret_key = 24'($urandom);
    start = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_wren !== 1'b0 || finish !== 1'b0) begin
      errors++; $display("FAIL abort_out got wren=%b fin=%b want 0 0", mem_wren, finish);
    end
    n = wa.size();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (wa.size() !== n || finish !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got writes=%0d fin=%b want %0d 0", wa.size(), finish, n);
    end
    run_full(24'($urandom), -1, 24'h0, base);
    end_run();
  endtask

  task automatic test_reset_midrun();
    logic prev, found;
    init_ram();
    secret_key = 24'($urandom);
    start = 1'b1;
    prev = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (mem_wren === 1'b1 && !prev) begin found = 1'b1; break; end
      prev = mem_wren;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL wr_i_seen got %b want 1", found);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_wren !== 1'b0 || finish !== 1'b0 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL async_reset got wren=%b fin=%b addr=%0d want 0 0 0",
                         mem_wren, finish, mem_addr);
    end
    start = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_latch();
    int base;
    run_full(24'h000000, 50, 24'hFFFFFF, base);
    end_run();
  endtask

  task automatic test_random();
    int base;
    for (int r = 0; r < 3; r++) begin
      run_full(24'($urandom), -1, 24'h0, base);
      end_run();
    end
  endtask

  initial begin
    test_reset();
    test_known_keys();
    test_handshake();
    test_abort();
    test_reset_midrun();
    test_key_latch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
